nn_smoothgrad_polar_bank: RTL and testbench

Multi-channel sign-magnitude stochastic parameter integrator with per-channel adaptive resistance. Each channel integrates a stochastic update bitstream (IN_SS) with a polarity bit (SIGN) into an N-bit magnitude plus sign register, stepping once every RESISTANCE+1 active input bits. On each detected direction reversal, a channel raises its own resistance; after a run of same-direction steps, it lowers it. The block sits in the training path between the gradient stochastic-stream generators and the weight/bias registers of a fully connected SNN layer.

---
 rtl/nn_smoothgrad_polar_bank_pkg.sv | 26 ++
 rtl/nn_smoothgrad_polar_bank_ch.sv | 115 +++++++++++
 rtl/nn_smoothgrad_polar_bank.sv | 60 ++++++
 tb/tb_nn_smoothgrad_polar_bank.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_smoothgrad_polar_bank_pkg.sv
// Shared helpers for the sign-magnitude stochastic integrator bank.
package nn_smoothgrad_polar_bank_pkg;

  // Saturate a loaded resistance into [lo, hi].
  function automatic int unsigned clamp_res(int unsigned v, int unsigned lo, int unsigned hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Resistance bounds must be ordered and representable in nr bits.
  function automatic bit res_range_ok(int unsigned lo, int unsigned hi, int unsigned nr);
    return (lo <= hi) && (hi <= ((32'd1 << nr) - 32'd1));
  endfunction

  // Width of the same-direction run counter; at least one bit even when decay is off.
  function automatic int unsigned run_width(int unsigned decay_steps);
    return (decay_steps == 0) ? 1 : $clog2(decay_steps + 1);
  endfunction

  // Low bit index of channel c in a bus packed w bits per channel.
  function automatic int unsigned slice_lo(int unsigned c, int unsigned w);
    return c * w;
  endfunction

endpackage

// File: rtl/nn_smoothgrad_polar_bank_ch.sv
// One channel: stochastic sign-magnitude integrator with adaptive resistance.
module nn_smoothgrad_polar_ch
  import nn_smoothgrad_polar_bank_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned NR          = 9,
  parameter int unsigned RES_MAX     = (1 << NR) - 1,
  parameter int unsigned RES_MIN     = 0,
  parameter int unsigned DECAY_STEPS = 16
) (
  input  logic          clk_i,
  input  logic          init_ni,
  input  logic          en_i,
  input  logic          adapt_en_i,
  input  logic          in_ss_i,
  input  logic          sign_i,
  input  logic [N-1:0]  out_init_i,
  input  logic          sign_out_init_i,
  input  logic [NR-1:0] res_init_i,
  output logic [N-1:0]  out_o,
  output logic          sign_out_o,
  output logic [NR-1:0] res_o,
  output logic          rev_pulse_o,
  output logic          sat_o
);

  localparam int unsigned RunW = run_width(DECAY_STEPS);
  localparam logic [N-1:0] OutMax = '1;

  logic [N-1:0]    out_q, out_d;
  logic            sign_q, sign_d;
  logic [NR-1:0]   flag_q, flag_d;
  logic [NR-1:0]   res_q, res_d;
  logic            last_dir_q, last_dir_d;
  logic            dir_valid_q, dir_valid_d;
  logic [RunW-1:0] run_q, run_d, run_inc;
  logic            rev_q, rev_d;
  logic [NR-1:0]   res_init_clamped;

  assign res_init_clamped = NR'(clamp_res(32'(res_init_i), RES_MIN, RES_MAX));

  // Next-state: count active bits until res is reached, then step and adapt.
  always_comb begin
    out_d       = out_q;
    sign_d      = sign_q;
    flag_d      = flag_q;
    res_d       = res_q;
    last_dir_d  = last_dir_q;
    dir_valid_d = dir_valid_q;
    run_d       = run_q;
    rev_d       = 1'b0;
    run_inc     = run_q + RunW'(1);
    if (en_i && in_ss_i) begin
      if (flag_q < res_q) begin
        flag_d = flag_q + NR'(1);
      end else begin
        flag_d = '0;
        // A zero magnitude has no sign of its own; the next step adopts SIGN.
        if (out_q == '0) begin
          out_d  = N'(1);
          sign_d = sign_i;
        end else if (sign_i == sign_q) begin
          if (out_q != OutMax) out_d = out_q + N'(1);
        end else begin
          out_d = out_q - N'(1);
        end
        if (adapt_en_i) begin
          if (dir_valid_q && (sign_i != last_dir_q)) begin
            if (res_q < NR'(RES_MAX)) res_d = res_q + NR'(1);
            run_d = '0;
            rev_d = 1'b1;
          end else begin
            run_d = run_inc;
            if ((DECAY_STEPS != 0) && (run_inc == RunW'(DECAY_STEPS))) begin
              if (res_q > NR'(RES_MIN)) res_d = res_q - NR'(1);
              run_d = '0;
            end
          end
          last_dir_d  = sign_i;
          dir_valid_d = 1'b1;
        end
      end
    end
  end

  // State register with synchronous active-low load of the init values.
  always_ff @(posedge clk_i) begin
    if (!init_ni) begin
      out_q       <= out_init_i;
      sign_q      <= sign_out_init_i;
      res_q       <= res_init_clamped;
      flag_q      <= '0;
      run_q       <= '0;
      last_dir_q  <= 1'b0;
      dir_valid_q <= 1'b0;
      rev_q       <= 1'b0;
    end else begin
      out_q       <= out_d;
      sign_q      <= sign_d;
      res_q       <= res_d;
      flag_q      <= flag_d;
      run_q       <= run_d;
      last_dir_q  <= last_dir_d;
      dir_valid_q <= dir_valid_d;
      rev_q       <= rev_d;
    end
  end

  assign out_o       = out_q;
  assign sign_out_o  = sign_q;
  assign res_o       = res_q;
  assign rev_pulse_o = rev_q;
  assign sat_o       = (out_q == OutMax);

endmodule

// File: rtl/nn_smoothgrad_polar_bank.sv
// Bank of independent stochastic sign-magnitude integrators.
module nn_smoothgrad_polar_bank
  import nn_smoothgrad_polar_bank_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned N           = 8,
  parameter int unsigned NR          = 9,
  parameter int unsigned RES_MAX     = (1 << NR) - 1,
  parameter int unsigned RES_MIN     = 0,
  parameter int unsigned DECAY_STEPS = 16
) (
  input  logic              CLK,
  input  logic              INIT_N,
  input  logic              EN,
  input  logic              ADAPT_EN,
  input  logic [NCH-1:0]    IN_SS,
  input  logic [NCH-1:0]    SIGN,
  input  logic [NCH*N-1:0]  OUT_INIT,
  input  logic [NCH-1:0]    SIGN_OUT_INIT,
  input  logic [NCH*NR-1:0] RES_INIT,
  output logic [NCH*N-1:0]  OUT,
  output logic [NCH-1:0]    SIGN_out,
  output logic [NCH*NR-1:0] RES_OUT,
  output logic [NCH-1:0]    REV_PULSE,
  output logic [NCH-1:0]    SAT
);

  if (!res_range_ok(RES_MIN, RES_MAX, NR)) begin : g_bad_range
    $error("RES_MIN/RES_MAX out of order or not representable in NR bits");
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam int unsigned OLo = slice_lo(c, N);
    localparam int unsigned RLo = slice_lo(c, NR);

    nn_smoothgrad_polar_ch #(
      .N           (N),
      .NR          (NR),
      .RES_MAX     (RES_MAX),
      .RES_MIN     (RES_MIN),
      .DECAY_STEPS (DECAY_STEPS)
    ) u_ch (
      .clk_i           (CLK),
      .init_ni         (INIT_N),
      .en_i            (EN),
      .adapt_en_i      (ADAPT_EN),
      .in_ss_i         (IN_SS[c]),
      .sign_i          (SIGN[c]),
      .out_init_i      (OUT_INIT[OLo +: N]),
      .sign_out_init_i (SIGN_OUT_INIT[c]),
      .res_init_i      (RES_INIT[RLo +: NR]),
      .out_o           (OUT[OLo +: N]),
      .sign_out_o      (SIGN_out[c]),
      .res_o           (RES_OUT[RLo +: NR]),
      .rev_pulse_o     (REV_PULSE[c]),
      .sat_o           (SAT[c])
    );
  end

endmodule

// File: tb/tb_nn_smoothgrad_polar_bank.sv
// Bench for nn_smoothgrad_polar_bank: directed table on channel 0 plus a per-cycle
// scoreboard fed by a behavioural model of every channel.
module tb_nn_smoothgrad_polar_bank;

  localparam int NCH  = 4;
  localparam int N    = 8;
  localparam int NR   = 9;
  localparam int RMAX = 8;
  localparam int RMIN = 0;
  localparam int DEC  = 4;

  logic              CLK = 1'b0;
  logic              INIT_N, EN, ADAPT_EN;
  logic [NCH-1:0]    IN_SS, SIGN, SIGN_OUT_INIT;
  logic [NCH*N-1:0]  OUT_INIT;
  logic [NCH*NR-1:0] RES_INIT;
  logic [NCH*N-1:0]  OUT;
  logic [NCH-1:0]    SIGN_out, REV_PULSE, SAT;
  logic [NCH*NR-1:0] RES_OUT;

  nn_smoothgrad_polar_bank #(
    .NCH(NCH), .N(N), .NR(NR), .RES_MAX(RMAX), .RES_MIN(RMIN), .DECAY_STEPS(DEC)
  ) dut (
    .CLK(CLK), .INIT_N(INIT_N), .EN(EN), .ADAPT_EN(ADAPT_EN), .IN_SS(IN_SS), .SIGN(SIGN),
    .OUT_INIT(OUT_INIT), .SIGN_OUT_INIT(SIGN_OUT_INIT), .RES_INIT(RES_INIT),
    .OUT(OUT), .SIGN_out(SIGN_out), .RES_OUT(RES_OUT), .REV_PULSE(REV_PULSE), .SAT(SAT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state, one entry per channel.
  int m_out[NCH], m_sgn[NCH], m_flag[NCH], m_res[NCH];
  int m_last[NCH], m_valid[NCH], m_run[NCH], m_rev[NCH];

  typedef struct {
    logic [NCH*N-1:0]  out;
    logic [NCH-1:0]    sgn;
    logic [NCH*NR-1:0] res;
    logic [NCH-1:0]    rev;
    logic [NCH-1:0]    sat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit init_n; bit en; bit adapt; bit ss; bit sg; int rep;
    int oi; bit si; int ri;
    int e_out; bit e_sgn; int e_res; bit e_rev;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_cycle();
    for (int c = 0; c < NCH; c++) begin
      int dir;
      dir = int'(SIGN[c]);
      if (!INIT_N) begin
        int ri;
        ri = int'(RES_INIT[c*NR +: NR]);
        m_out[c] = int'(OUT_INIT[c*N +: N]);
        m_sgn[c] = int'(SIGN_OUT_INIT[c]);
        m_res[c] = (ri > RMAX) ? RMAX : ((ri < RMIN) ? RMIN : ri);
        m_flag[c] = 0; m_run[c] = 0; m_valid[c] = 0; m_rev[c] = 0; m_last[c] = 0;
      end else if (!EN || !IN_SS[c]) begin
        m_rev[c] = 0;
      end else if (m_flag[c] < m_res[c]) begin
        m_flag[c]++;
        m_rev[c] = 0;
      end else begin
        m_flag[c] = 0;
        m_rev[c] = 0;
        if (m_out[c] == 0) begin
          m_out[c] = 1; m_sgn[c] = dir;
        end else if (dir == m_sgn[c]) begin
          if (m_out[c] < 255) m_out[c]++;
        end else begin
          m_out[c]--;
        end
        if (ADAPT_EN) begin
          if (m_valid[c] != 0 && dir != m_last[c]) begin
            if (m_res[c] < RMAX) m_res[c]++;
            m_run[c] = 0;
            m_rev[c] = 1;
          end else begin
            m_run[c]++;
            if (m_run[c] == DEC) begin
              if (m_res[c] > RMIN) m_res[c]--;
              m_run[c] = 0;
            end
          end
          m_last[c] = dir;
          m_valid[c] = 1;
        end
      end
    end
  endtask

  // Push the model's prediction, clock the DUT, then pop and compare.
  task automatic run_cycle();
    exp_t e;
    model_cycle();
    for (int c = 0; c < NCH; c++) begin
      e.out[c*N +: N]   = 8'(m_out[c]);
      e.sgn[c]          = 1'(m_sgn[c]);
      e.res[c*NR +: NR] = 9'(m_res[c]);
      e.rev[c]          = 1'(m_rev[c]);
      e.sat[c]          = (m_out[c] == 255);
    end
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("sb_out", 64'(OUT), 64'(e.out));
      check("sb_sign", 64'(SIGN_out), 64'(e.sgn));
      check("sb_res", 64'(RES_OUT), 64'(e.res));
      check("sb_rev", 64'(REV_PULSE), 64'(e.rev));
      check("sb_sat", 64'(SAT), 64'(e.sat));
    end
  endtask

  task automatic add(input bit init_n, input bit en, input bit adapt, input bit ss, input bit sg,
                     input int rep, input int oi, input bit si, input int ri,
                     input int e_out, input bit e_sgn, input int e_res, input bit e_rev);
    vec_t v;
    v = '{init_n, en, adapt, ss, sg, rep, oi, si, ri, e_out, e_sgn, e_res, e_rev};
    vt.push_back(v);
  endtask

  initial begin
    // Fields: init_n en adapt ss sg rep | oi si ri | exp out sign res rev (channel 0).
    // Accumulate with res=3: a step every 4th active cycle.
    add(0, 1, 0, 0, 0, 1,   5, 0, 3,   5, 0, 3, 0);
    add(1, 1, 0, 1, 0, 3,   0, 0, 0,   5, 0, 3, 0);
    add(1, 1, 0, 1, 0, 1,   0, 0, 0,   6, 0, 3, 0);
    add(1, 1, 0, 1, 0, 3,   0, 0, 0,   6, 0, 3, 0);
    add(1, 1, 0, 1, 0, 1,   0, 0, 0,   7, 0, 3, 0);
    // Sign change through zero.
    add(0, 1, 0, 0, 0, 1,   1, 0, 0,   1, 0, 0, 0);
    add(1, 1, 0, 1, 1, 1,   0, 0, 0,   0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 1,   0, 0, 0,   1, 1, 0, 0);
    // Saturation at 255 then back off.
    add(0, 1, 0, 0, 0, 1, 255, 0, 0, 255, 0, 0, 0);
    add(1, 1, 0, 1, 0, 4,   0, 0, 0, 255, 0, 0, 0);
    add(1, 1, 0, 1, 1, 1,   0, 0, 0, 254, 0, 0, 0);
    // Loaded resistance above RES_MAX is clamped.
    add(0, 1, 0, 0, 0, 1,   0, 0, 20,  0, 0, 8, 0);
    // Reversals raise resistance up to RES_MAX=8.
    add(0, 1, 1, 0, 0, 1,  10, 0, 6,  10, 0, 6, 0);
    add(1, 1, 1, 1, 0, 6,   0, 0, 0,  10, 0, 6, 0);
    add(1, 1, 1, 1, 0, 1,   0, 0, 0,  11, 0, 6, 0);
    add(1, 1, 1, 1, 1, 7,   0, 0, 0,  10, 0, 7, 1);
    add(1, 1, 1, 1, 0, 8,   0, 0, 0,  11, 0, 8, 1);
    add(1, 1, 1, 1, 1, 9,   0, 0, 0,  10, 0, 8, 1);
    add(1, 1, 1, 1, 1, 1,   0, 0, 0,  10, 0, 8, 0);
    // Decay after 4 same-direction steps; gaps are not counted.
    add(0, 1, 1, 0, 0, 1,   0, 0, 5,   0, 0, 5, 0);
    add(1, 1, 1, 1, 0, 6,   0, 0, 0,   1, 0, 5, 0);
    add(1, 1, 1, 1, 0, 6,   0, 0, 0,   2, 0, 5, 0);
    add(1, 1, 1, 1, 0, 6,   0, 0, 0,   3, 0, 5, 0);
    add(1, 1, 1, 1, 0, 6,   0, 0, 0,   4, 0, 4, 0);
    add(1, 0, 1, 1, 0, 10,  0, 0, 0,   4, 0, 4, 0);
    add(1, 1, 1, 0, 0, 10,  0, 0, 0,   4, 0, 4, 0);
    add(1, 1, 1, 1, 0, 4,   0, 0, 0,   4, 0, 4, 0);
    add(1, 1, 1, 1, 0, 1,   0, 0, 0,   5, 0, 4, 0);
    // Mid-count reset discards the partial count.
    add(0, 1, 0, 0, 1, 1,  50, 1, 3,  50, 1, 3, 0);
    add(1, 1, 0, 1, 1, 2,   0, 0, 0,  50, 1, 3, 0);
    add(0, 1, 0, 1, 1, 1,  50, 1, 3,  50, 1, 3, 0);
    add(1, 1, 0, 1, 1, 3,   0, 0, 0,  50, 1, 3, 0);
    add(1, 1, 0, 1, 1, 1,   0, 0, 0,  51, 1, 3, 0);

    INIT_N = 1'b0; EN = 1'b0; ADAPT_EN = 1'b0; IN_SS = '0; SIGN = '0;
    OUT_INIT = '0; SIGN_OUT_INIT = '0; RES_INIT = '0;
    @(negedge CLK);

    foreach (vt[i]) begin
      for (int r = 0; r < vt[i].rep; r++) begin
        INIT_N   = vt[i].init_n;
        EN       = vt[i].en;
        ADAPT_EN = vt[i].adapt;
        IN_SS    = {3'($urandom), vt[i].ss};
        SIGN     = {3'($urandom), vt[i].sg};
        for (int c = 1; c < NCH; c++) begin
          OUT_INIT[c*N +: N]   = 8'($urandom);
          RES_INIT[c*NR +: NR] = 9'($urandom_range(12, 0));
        end
        OUT_INIT[N-1:0]  = 8'(vt[i].oi);
        RES_INIT[NR-1:0] = 9'(vt[i].ri);
        SIGN_OUT_INIT    = {3'($urandom), vt[i].si};
        run_cycle();
      end
      check($sformatf("row%0d_out", i), 64'(OUT[N-1:0]), 64'(vt[i].e_out));
      check($sformatf("row%0d_sign", i), 64'(SIGN_out[0]), 64'(vt[i].e_sgn));
      check($sformatf("row%0d_res", i), 64'(RES_OUT[NR-1:0]), 64'(vt[i].e_res));
      check($sformatf("row%0d_rev", i), 64'(REV_PULSE[0]), 64'(vt[i].e_rev));
    end

    // Mixed random traffic on all channels with occasional reloads.
    for (int k = 0; k < 600; k++) begin
      INIT_N   = ($urandom_range(99, 0) >= 2);
      EN       = ($urandom_range(3, 0) != 0);
      ADAPT_EN = ($urandom_range(4, 0) != 0);
      IN_SS    = 4'($urandom);
      SIGN     = ($urandom_range(1, 0) != 0) ? 4'($urandom) : SIGN;
      for (int c = 0; c < NCH; c++) begin
        OUT_INIT[c*N +: N]   = 8'($urandom);
        RES_INIT[c*NR +: NR] = 9'($urandom_range(12, 0));
      end
      SIGN_OUT_INIT = 4'($urandom);
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
